// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver state encoding and a
// frame-length helper used by both the receiver and the transmitter.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Number of bit periods in a frame after the start bit.
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Oversample tick counter: counts enable strobes modulo OVERSAMPLE, flags the
// half-bit and full-bit terminal counts. Zero latency on the flags (decoded
// from the count register); no backpressure, clear has priority over enable.
// Ports: clock/reset, clear, enable in; half, full terminal flags out.
module uart_tick_counter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half,
  output logic full
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0] count;

  // Flags mark the tick that completes half / a full bit period when it lands.
  assign half = (count == CNT_W'(OVERSAMPLE / 2 - 1));
  assign full = (count == CNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= full ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, parity/stop check.
// Latency: rx_valid one clock after the final stop-bit sample tick.
// No backpressure: rx_valid is a one-clock strobe, a missed word is lost.
// Ports: clock, reset, sample_tick, rx in; rx_data, rx_valid, parity_err,
// frame_err, busy out.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_rx_ctrl: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $fatal(1, "uart_rx_ctrl: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_rx_ctrl: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $fatal(1, "uart_rx_ctrl: OVERSAMPLE must be even and >= 4");
  end

  localparam int BIT_W = $clog2(frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  rx_state_t            state;
  logic                 armed;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_pend;
  logic                 frame_pend;
  logic                 tick_half;
  logic                 tick_full;
  logic                 start_detect;
  logic                 tick_clear;

  assign start_detect = sample_tick && (state == IDLE) && !rx && armed;
  // Realign the counter at start detect and again at the start-bit midpoint,
  // so every later full-period terminal count falls mid-bit.
  assign tick_clear   = start_detect || (sample_tick && (state == START) && tick_half);
  assign busy         = (state != IDLE);

  uart_tick_counter #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick_counter (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .enable(sample_tick),
    .half  (tick_half),
    .full  (tick_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_pend <= 1'b0;
      frame_pend  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_tick) begin
        // Any high sample rearms; a held-low break cannot start a new frame.
        if (rx) armed <= 1'b1;
        case (state)
          IDLE: begin
            if (start_detect) begin
              state       <= START;
              armed       <= 1'b0;
              bit_cnt     <= '0;
              parity_pend <= 1'b0;
              frame_pend  <= 1'b0;
            end
          end
          START: begin
            if (tick_half) state <= rx ? IDLE : DATA;
          end
          DATA: begin
            if (tick_full) begin
              shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= '0;
                state   <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          PARITY: begin
            if (tick_full) begin
              if ((^shift_reg ^ rx) != (PARITY_MODE == PARITY_ODD)) parity_pend <= 1'b1;
              state <= STOP;
            end
          end
          STOP: begin
            if (tick_full) begin
              if (bit_cnt == LAST_STOP) begin
                rx_data    <= shift_reg;
                parity_err <= parity_pend;
                frame_err  <= frame_pend | ~rx;
                rx_valid   <= 1'b1;
                bit_cnt    <= '0;
                state      <= IDLE;
              end else begin
                if (!rx) frame_pend <= 1'b1;
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receive controller: detects the start bit on an oversampled serial line, samples each bit at mid-point, shifts in a configurable-width data word, checks optional parity and one or two stop bits, then presents the word with a one-cycle valid strobe and error flags. Sits between the rx input synchroniser and the receive FIFO and handles the complete frame, including mid-bit timing and the data shift register.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- OVERSAMPLE, 16: sample_tick strobes per bit period, even, ≥4.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sample_tick  in  1  oversample enable strobe, one clock wide.
- rx  in  1  serial line, already synchronised to clock, idle high.
- rx_data  out  DATA_BITS  last received word, LSB = first bit on line.
- rx_valid  out  1  one-clock pulse: rx_data and error flags are updated.
- parity_err  out  1  parity mismatch on the word flagged by rx_valid.
- frame_err  out  1  a stop bit was sampled low on the word flagged by rx_valid.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE = 0.
- Tick counter, width clog2(OVERSAMPLE), advances only on sample_tick. Bit counter counts DATA_BITS data bits, then STOP_BITS stop bits.
- IDLE: on sample_tick with rx = 0 and armed = 1, go to START and clear the tick counter.
- armed is set by any sample_tick with rx = 1. It is cleared on entry to START. A held-low line (break) therefore cannot retrigger reception.
- START: after OVERSAMPLE/2 ticks, sample rx.
  - rx = 1: false start, return to IDLE with no rx_valid.
  - rx = 0: go to DATA.
- DATA: sample every OVERSAMPLE ticks and shift right into the MSB, so the first bit lands in bit 0 after DATA_BITS samples. After the last data sample go to PARITY or STOP.
- PARITY: sample one bit. Even mode requires the XOR of data and parity bit to be 0; odd mode requires it to be 1. A mismatch latches a pending parity error. The frame is not aborted; reception continues into STOP.
- STOP: sample STOP_BITS bits. Any low sample latches a pending frame error.
- After the final stop sample, in the same clock: update rx_data, parity_err and frame_err, pulse rx_valid, and return to IDLE.
- rx_data, parity_err and frame_err hold their values until the next rx_valid.
- No back-pressure: a consumer that misses the rx_valid pulse loses the word.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0. State is IDLE, armed = 0, counters = 0.
- Bit sample points: (OVERSAMPLE/2 + k·OVERSAMPLE) ticks after the start-detect tick, for k = 1 .. frame bits after start.
- rx_valid is registered. It rises on the clock edge of the final stop-bit sample tick, plus one clock.
- Ticks spaced one clock apart are legal. With continuous ticks, OVERSAMPLE = 16, 8N1, the frame takes 8 + 9·16 = 152 clocks from start detect to rx_valid.
- sample_tick low: all state frozen.
- Asserting reset mid-frame aborts the frame: no rx_valid, outputs at reset values. The block is rearmed only after rx is seen high.
- A start bit arriving on the tick immediately after rx_valid is accepted, provided armed = 1 (the stop bit sampled high sets it).

## Structure
- Shared package uart_pkg:
  - parity mode constants PARITY_NONE / PARITY_EVEN / PARITY_ODD.
  - state enum rx_state_t.
  - helper function frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS).
- One sub-module, uart_tick_counter: the OVERSAMPLE counter, with clear, enable and half/full terminal outputs. The same sub-module is reused by the transmitter.
- Parameter legality is checked at elaboration; illegal values are a fatal error.

## Test plan
- 8N1, OVERSAMPLE = 16, continuous ticks, send 0xA5 → rx_data = 0xA5, rx_valid once, 152 clocks after start detect, no errors.
- 8E1, send 0x3C with parity bit 1 (wrong) → rx_data = 0x3C, parity_err = 1, frame_err = 0. The following 0x3C frame with parity 0 → parity_err = 0.
- 7O2, send 0x41 with the second stop bit low → rx_data = 0x41, frame_err = 1.
- 8N1, line low for 8 ticks then high (glitch) → no rx_valid, busy returns to 0. A break (rx low for 40 bit times) → exactly one rx_valid with frame_err = 1 and rx_data = 0x00, and no further frames until rx returns high.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap; ticks every 3 clocks → three rx_valid pulses, correct data, no errors.
- reset asserted midway through the DATA bits of 0x96 → outputs return to reset values immediately, no rx_valid. The next clean 0x96 frame after rx idles high is received correctly.
